// File: rtl/jtag_reg_sched.sv
// jtag_reg_sched: bridges the LM32 JTAG register interface to the CPU side.
// The asynchronous update strobe is synchronised into clk_i and edge-detected.
// Each update edge latches one {code, arg} command. A small FSM then runs the
// command against one of three targets: the RX byte FIFO, the TX holding
// register, or the debug strobe. The TX byte and a 3-bit status word are
// driven back to the host for its next scan.
//
// Handshakes: a transfer happens on a rising clk_i edge where both valid and
// ready are high. tx_valid/tx_ready follow this rule. For the RX side,
// rx_valid acts as valid and rx_ack as ready. rx_ack is ignored while
// rx_valid is low. valid never waits for ready.
//
// The FSM state is the internal signal `state`, so checkers can bind to it
// hierarchically.
module jtag_reg_sched #(
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       jtag_reg_update,
  input  logic [7:0] jtag_reg_q,
  input  logic [2:0] jtag_reg_addr_q,
  output logic [7:0] jtag_reg_d,
  output logic [2:0] jtag_reg_addr_d,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [2:0] dbg_cmd,
  output logic [7:0] dbg_arg,
  output logic       dbg_stb,
  input  logic       dbg_busy
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_PUSH   = 3'd1;
  localparam logic [2:0] CMD_TX_ACK = 3'd2;
  localparam logic [2:0] CMD_CLR    = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    DBG_WAIT = 2'd2
  } state_t;

  state_t state;

  // Synchroniser and edge history. Both reset to 1, so an update that is
  // still high when reset is released is not seen as a new edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_out;
  logic                   upd_rise;

  // Pending slot: holds one command until the FSM takes it.
  logic       pend_q;
  logic [2:0] pend_code;
  logic [7:0] pend_arg;

  // Command being executed.
  logic [2:0] cmd_q;
  logic [7:0] arg_q;

  // RX FIFO storage and pointers.
  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // TX holding register and sticky status.
  logic [7:0] tx_q;
  logic       tx_pending;
  logic       overflow;

  logic take;
  logic in_exec;
  logic exec_push;
  logic pop;
  logic push_ok;
  logic push_ovf;
  logic drop_ovf;
  logic rx_full;
  logic tx_load;
  logic is_dbg;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign upd_rise  = sync_out & ~hist_q;
  assign take      = (state == IDLE) & pend_q;
  assign in_exec   = (state == EXEC);
  assign is_dbg    = (cmd_q >= 3'd3) && (cmd_q <= 3'd6);
  assign exec_push = in_exec & (cmd_q == CMD_PUSH);
  assign rx_valid  = (count != '0);
  assign rx_full   = (count == CW'(RX_DEPTH));
  assign pop       = rx_ack & rx_valid;
  // A pop in the same cycle makes room, even when the FIFO is full.
  assign push_ok   = exec_push & (~rx_full | pop);
  assign push_ovf  = exec_push & ~push_ok;
  // A second edge that arrives while the slot is still occupied is lost.
  assign drop_ovf  = upd_rise & pend_q;
  assign tx_ready  = ~tx_pending;
  assign tx_load   = tx_valid & ~tx_pending;
  assign rx_data   = mem[rd_ptr];

  assign jtag_reg_d      = tx_q;
  assign jtag_reg_addr_d = {overflow, rx_full, tx_pending};

  // Move the update strobe into clk_i and keep one cycle of history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], jtag_reg_update};
      hist_q <= sync_out;
    end
  end

  // Capture a new command into the free pending slot, or release the slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q    <= 1'b0;
      pend_code <= 3'd0;
      pend_arg  <= 8'h00;
    end else if (upd_rise && !pend_q) begin
      pend_q    <= 1'b1;
      pend_code <= jtag_reg_addr_q;
      pend_arg  <= jtag_reg_q;
    end else if (take) begin
      pend_q <= 1'b0;
    end
  end

  // Command FSM. dbg_cmd, dbg_arg and dbg_stb are registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cmd_q   <= CMD_NOP;
      arg_q   <= 8'h00;
      dbg_cmd <= 3'd0;
      dbg_arg <= 8'h00;
      dbg_stb <= 1'b0;
    end else begin
      dbg_stb <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend_q) begin
            cmd_q <= pend_code;
            arg_q <= pend_arg;
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= IDLE;
          if (is_dbg) begin
            dbg_cmd <= cmd_q;
            dbg_arg <= arg_q;
            if (dbg_busy) state <= DBG_WAIT;
            else          dbg_stb <= 1'b1;
          end
        end
        DBG_WAIT: begin
          if (!dbg_busy) begin
            dbg_stb <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RX FIFO: fall-through head, with push from EXEC and pop from rx_ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RX_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= arg_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // TX holding register. The CPU fills it and the host's TX_ACK frees it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q       <= 8'h00;
      tx_pending <= 1'b0;
    end else if (tx_load) begin
      tx_q       <= tx_data;
      tx_pending <= 1'b1;
    end else if (in_exec && cmd_q == CMD_TX_ACK) begin
      tx_pending <= 1'b0;
    end
  end

  // Sticky overflow. A new event in the same cycle wins over CLR_STATUS.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow <= 1'b0;
    end else begin
      overflow <= (overflow & ~(in_exec && cmd_q == CMD_CLR)) | drop_ovf | push_ovf;
    end
  end

endmodule
